// File: rtl/decode_fwd_stage_pkg.sv
// Shared definitions for the decode/forward stage: instruction codes and
// small helpers used by the decoder and hazard logic.
package decode_fwd_stage_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVQ  = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // Function code carried by an inserted bubble.
    localparam logic [3:0] BUBBLE_IFUN = 4'h0;

    // Instructions whose memory read result only becomes available in M,
    // so a consumer directly behind them in D has to wait a cycle.
    function automatic logic isLoad(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/decode_fwd_stage_if.sv
// D->E pipeline bus: decoded instruction fields coming out of the D register
// and the registered E-stage fields going on to execute.
interface decode_fwd_stage_if #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 4
);
    logic [3:0]        D_icode;
    logic [3:0]        D_ifun;
    logic [REG_AW-1:0] D_rA;
    logic [REG_AW-1:0] D_rB;
    logic [DATA_W-1:0] D_valC;
    logic [DATA_W-1:0] D_valP;

    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valC;
    logic [DATA_W-1:0] E_valA;
    logic [DATA_W-1:0] E_valB;
    logic [REG_AW-1:0] E_srcA;
    logic [REG_AW-1:0] E_srcB;
    logic [REG_AW-1:0] E_dstE;
    logic [REG_AW-1:0] E_dstM;

    // Fetch/D side drives the D fields and observes E.
    modport master (
        output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_srcA, E_srcB, E_dstE, E_dstM
    );

    // The decode stage consumes D and produces the E register contents.
    modport slave (
        input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_srcA, E_srcB, E_dstE, E_dstM
    );
endinterface

// File: rtl/decode_fwd_stage_regfile.sv
// Architectural register file: two combinational read ports returning the
// pre-write value, two write ports from writeback where the M port wins a
// collision on the same register.
module decode_regfile #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 4,
    parameter int NREGS  = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rdIdxA_i,
    input  logic [REG_AW-1:0] rdIdxB_i,
    output logic [DATA_W-1:0] rdDataA_o,
    output logic [DATA_W-1:0] rdDataB_o,
    input  logic [REG_AW-1:0] wrIdxE_i,
    input  logic [DATA_W-1:0] wrDataE_i,
    input  logic [REG_AW-1:0] wrIdxM_i,
    input  logic [DATA_W-1:0] wrDataM_i
);

    // One extra bit so NREGS itself is representable for the range check.
    localparam logic [REG_AW:0] NREGS_LIM = (REG_AW + 1)'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];

    // Per-register update; the M port is tested first so it takes priority.
    // Indices outside the implemented range never match and are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wrIdxM_i == REG_AW'(i)) begin
                    regs_q[i] <= wrDataM_i;
                end else if (wrIdxE_i == REG_AW'(i)) begin
                    regs_q[i] <= wrDataE_i;
                end
            end
        end
    end

    // Combinational reads; unimplemented indices (including RNONE) read 0.
    always_comb begin
        rdDataA_o = '0;
        rdDataB_o = '0;
        if ({1'b0, rdIdxA_i} < NREGS_LIM) begin
            rdDataA_o = regs_q[rdIdxA_i];
        end
        if ({1'b0, rdIdxB_i} < NREGS_LIM) begin
            rdDataB_o = regs_q[rdIdxB_i];
        end
    end

endmodule

// File: rtl/decode_fwd_stage.sv
// Decode stage: source/destination decode, operand forwarding from E/M/W,
// load-use hazard detection and the D->E pipeline register.
module decode_fwd_stage
    import decode_fwd_stage_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 4,
    parameter int NREGS   = 15,
    parameter int RSP_IDX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    decode_fwd_stage_if.slave   dbus,
    input  logic [REG_AW-1:0]   e_dstE_i,
    input  logic [DATA_W-1:0]   e_valE_i,
    input  logic [REG_AW-1:0]   M_dstE_i,
    input  logic [DATA_W-1:0]   M_valE_i,
    input  logic [REG_AW-1:0]   M_dstM_i,
    input  logic [DATA_W-1:0]   m_valM_i,
    input  logic [REG_AW-1:0]   W_dstE_i,
    input  logic [DATA_W-1:0]   W_valE_i,
    input  logic [REG_AW-1:0]   W_dstM_i,
    input  logic [DATA_W-1:0]   W_valM_i,
    input  logic                flush_i,
    input  logic                hold_i,
    output logic                d_stall_o
);

    localparam logic [REG_AW-1:0] RNONE = '1;
    localparam logic [REG_AW-1:0] RRSP  = REG_AW'(RSP_IDX);

    logic [REG_AW-1:0] srcA_d, srcB_d, dstE_d, dstM_d;
    logic [DATA_W-1:0] rdDataA, rdDataB;
    logic [DATA_W-1:0] valA_d, valB_d;
    logic              loadUse;
    logic              insertBubble;

    logic [3:0]        eIcode_q, eIfun_q;
    logic [DATA_W-1:0] eValC_q, eValA_q, eValB_q;
    logic [REG_AW-1:0] eSrcA_q, eSrcB_q, eDstE_q, eDstM_q;

    decode_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .NREGS  (NREGS)
    ) uRegfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rdIdxA_i  (srcA_d),
        .rdIdxB_i  (srcB_d),
        .rdDataA_o (rdDataA),
        .rdDataB_o (rdDataB),
        .wrIdxE_i  (W_dstE_i),
        .wrDataE_i (W_valE_i),
        .wrIdxM_i  (W_dstM_i),
        .wrDataM_i (W_valM_i)
    );

    // Youngest producer wins; memory data in M beats the ALU result in M,
    // and likewise in W. RNONE never matches any producer.
    function automatic logic [DATA_W-1:0] fwdSel(input logic [REG_AW-1:0] src,
                                                 input logic [DATA_W-1:0] rfData);
        logic [DATA_W-1:0] res;
        res = rfData;
        if (src == RNONE)          res = '0;
        else if (src == e_dstE_i)  res = e_valE_i;
        else if (src == M_dstM_i)  res = m_valM_i;
        else if (src == M_dstE_i)  res = M_valE_i;
        else if (src == W_dstM_i)  res = W_valM_i;
        else if (src == W_dstE_i)  res = W_valE_i;
        return res;
    endfunction

    // Which register fields each instruction reads and writes.
    always_comb begin
        srcA_d = RNONE;
        srcB_d = RNONE;
        dstE_d = RNONE;
        dstM_d = RNONE;
        case (dbus.D_icode)
            I_CMOVQ: begin
                srcA_d = dbus.D_rA;
                dstE_d = dbus.D_rB;
            end
            I_IRMOVQ: begin
                dstE_d = dbus.D_rB;
            end
            I_MRMOVQ: begin
                srcB_d = dbus.D_rB;
                dstM_d = dbus.D_rA;
            end
            I_RMMOVQ: begin
                srcA_d = dbus.D_rA;
                srcB_d = dbus.D_rB;
            end
            I_OPQ: begin
                srcA_d = dbus.D_rA;
                srcB_d = dbus.D_rB;
                dstE_d = dbus.D_rB;
            end
            I_PUSHQ: begin
                srcA_d = dbus.D_rA;
                srcB_d = RRSP;
                dstE_d = RRSP;
            end
            I_POPQ: begin
                srcA_d = RRSP;
                srcB_d = RRSP;
                dstE_d = RRSP;
                dstM_d = dbus.D_rA;
            end
            I_CALL: begin
                srcB_d = RRSP;
                dstE_d = RRSP;
            end
            I_RET: begin
                srcA_d = RRSP;
                srcB_d = RRSP;
                dstE_d = RRSP;
            end
            default: begin
            end
        endcase
    end

    // Operand selection; call and jump carry the fall-through PC in valA.
    always_comb begin
        valA_d = fwdSel(srcA_d, rdDataA);
        valB_d = fwdSel(srcB_d, rdDataB);
        if ((dbus.D_icode == I_CALL) || (dbus.D_icode == I_JXX)) begin
            valA_d = dbus.D_valP;
        end
    end

    // A load in E cannot forward its data yet, so a dependent D must wait.
    always_comb begin
        loadUse = isLoad(eIcode_q) && (eDstM_q != RNONE) &&
                  ((eDstM_q == srcA_d) || (eDstM_q == srcB_d));
        insertBubble = flush_i || loadUse;
    end

    assign d_stall_o = loadUse;

    // E register: reset and bubble load a NOP, hold freezes, else take D.
    always_ff @(posedge clk_i) begin
        if (rst_i || (!hold_i && insertBubble)) begin
            eIcode_q <= I_NOP;
            eIfun_q  <= BUBBLE_IFUN;
            eValC_q  <= '0;
            eValA_q  <= '0;
            eValB_q  <= '0;
            eSrcA_q  <= RNONE;
            eSrcB_q  <= RNONE;
            eDstE_q  <= RNONE;
            eDstM_q  <= RNONE;
        end else if (!hold_i) begin
            eIcode_q <= dbus.D_icode;
            eIfun_q  <= dbus.D_ifun;
            eValC_q  <= dbus.D_valC;
            eValA_q  <= valA_d;
            eValB_q  <= valB_d;
            eSrcA_q  <= srcA_d;
            eSrcB_q  <= srcB_d;
            eDstE_q  <= dstE_d;
            eDstM_q  <= dstM_d;
        end
    end

    assign dbus.E_icode = eIcode_q;
    assign dbus.E_ifun  = eIfun_q;
    assign dbus.E_valC  = eValC_q;
    assign dbus.E_valA  = eValA_q;
    assign dbus.E_valB  = eValB_q;
    assign dbus.E_srcA  = eSrcA_q;
    assign dbus.E_srcB  = eSrcB_q;
    assign dbus.E_dstE  = eDstE_q;
    assign dbus.E_dstM  = eDstM_q;

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Testbench for decode_fwd_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the register file and E register.
module tb_decode_fwd_stage;
    import decode_fwd_stage_pkg::*;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int NR = 15;
    localparam logic [3:0] RN  = 4'hF;
    localparam logic [3:0] RSP = 4'h4;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } ereg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        flush, hold, d_stall;

    int errors = 0;
    int checks = 0;

    logic [63:0] mregs [16];
    ereg_t       mE;

    decode_fwd_stage_if #(.DATA_W(DW), .REG_AW(AW)) dbus ();

    decode_fwd_stage #(.DATA_W(DW), .REG_AW(AW), .NREGS(NR), .RSP_IDX(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .dbus      (dbus),
        .e_dstE_i  (e_dstE),
        .e_valE_i  (e_valE),
        .M_dstE_i  (M_dstE),
        .M_valE_i  (M_valE),
        .M_dstM_i  (M_dstM),
        .m_valM_i  (m_valM),
        .W_dstE_i  (W_dstE),
        .W_valE_i  (W_valE),
        .W_dstM_i  (W_dstM),
        .W_valM_i  (W_valM),
        .flush_i   (flush),
        .hold_i    (hold),
        .d_stall_o (d_stall)
    );

    function automatic ereg_t bubble();
        ereg_t b;
        b = '{icode: 4'h1, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
              srcA: RN, srcB: RN, dstE: RN, dstM: RN};
        return b;
    endfunction

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] rA);
        if (ic inside {I_CMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) return rA;
        if (ic inside {I_POPQ, I_RET}) return RSP;
        return RN;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rB);
        if (ic inside {I_MRMOVQ, I_RMMOVQ, I_OPQ}) return rB;
        if (ic inside {I_PUSHQ, I_POPQ, I_CALL, I_RET}) return RSP;
        return RN;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rB);
        if (ic inside {I_CMOVQ, I_IRMOVQ, I_OPQ}) return rB;
        if (ic inside {I_PUSHQ, I_POPQ, I_CALL, I_RET}) return RSP;
        return RN;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] rA);
        if (ic inside {I_MRMOVQ, I_POPQ}) return rA;
        return RN;
    endfunction

    // Value seen for a source: first matching producer in age order, then storage.
    function automatic logic [63:0] m_read(input logic [3:0] src);
        logic [3:0]  d [5];
        logic [63:0] v [5];
        d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == RN) return 64'h0;
        for (int k = 0; k < 5; k++) begin
            if (d[k] == src) return v[k];
        end
        return (int'(src) < NR) ? mregs[src] : 64'h0;
    endfunction

    function automatic logic m_load_use();
        logic [3:0] sA, sB;
        sA = m_srcA(dbus.D_icode, dbus.D_rA);
        sB = m_srcB(dbus.D_icode, dbus.D_rB);
        return (mE.icode inside {I_MRMOVQ, I_POPQ}) && (mE.dstM != RN) &&
               (mE.dstM == sA || mE.dstM == sB);
    endfunction

    function automatic ereg_t dut_e();
        ereg_t r;
        r = {dbus.E_icode, dbus.E_ifun, dbus.E_valC, dbus.E_valA, dbus.E_valB,
             dbus.E_srcA, dbus.E_srcB, dbus.E_dstE, dbus.E_dstM};
        return r;
    endfunction

    // Advance one clock and move the model along with it.
    task automatic step();
        ereg_t nx;
        logic  lu;
        nx.icode = dbus.D_icode;
        nx.ifun  = dbus.D_ifun;
        nx.valC  = dbus.D_valC;
        nx.srcA  = m_srcA(dbus.D_icode, dbus.D_rA);
        nx.srcB  = m_srcB(dbus.D_icode, dbus.D_rB);
        nx.dstE  = m_dstE(dbus.D_icode, dbus.D_rB);
        nx.dstM  = m_dstM(dbus.D_icode, dbus.D_rA);
        nx.valA  = (dbus.D_icode inside {I_CALL, I_JXX}) ? dbus.D_valP : m_read(nx.srcA);
        nx.valB  = m_read(nx.srcB);
        lu = m_load_use();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) mregs[i] = 64'h0;
            mE = bubble();
        end else begin
            if (int'(W_dstE) < NR) mregs[W_dstE] = W_valE;
            if (int'(W_dstM) < NR) mregs[W_dstM] = W_valM;
            if (!hold) mE = (flush || lu) ? bubble() : nx;
        end
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
        e_dstE = RN; M_dstE = RN; M_dstM = RN; W_dstE = RN; W_dstM = RN;
        e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_valE = 64'h0; W_valM = 64'h0;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] rA, input logic [3:0] rB,
                         input logic [63:0] valC, input logic [63:0] valP);
        dbus.D_icode = ic; dbus.D_ifun = 4'h0; dbus.D_rA = rA; dbus.D_rB = rB;
        dbus.D_valC = valC; dbus.D_valP = valP;
    endtask

    task automatic do_reset();
        clear_inputs();
        set_d(I_NOP, RN, RN, 64'h0, 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_e() !== bubble()) begin
            errors++;
            $display("[TB] FAIL reset_e_bubble got=%h exp=%h", dut_e(), bubble());
        end
        checks++;
        if (d_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall got=%b exp=0", d_stall);
        end
        set_d(I_OPQ, 4'd0, 4'd1, 64'h0, 64'h0);
        step();
        checks++;
        if (dbus.E_valA !== 64'h0 || dbus.E_valB !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs_zero got=%h/%h exp=0/0", dbus.E_valA, dbus.E_valB);
        end
    endtask

    task automatic test_fwd_e();
        do_reset();
        set_d(I_IRMOVQ, RN, 4'd0, 64'd5, 64'h0);
        step();
        set_d(I_OPQ, 4'd0, 4'd3, 64'h0, 64'h0);
        e_dstE = 4'd0; e_valE = 64'd5;
        #1;
        checks++;
        if (d_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwd_e_stall got=%b exp=0", d_stall);
        end
        step();
        checks++;
        if (dbus.E_valA !== 64'd5) begin
            errors++;
            $display("[TB] FAIL fwd_e_valA got=%h exp=5", dbus.E_valA);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(I_MRMOVQ, 4'd0, 4'd1, 64'h0, 64'h0);
        step();
        set_d(I_OPQ, 4'd0, 4'd2, 64'h0, 64'h0);
        #1;
        checks++;
        if (d_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_use_stall got=%b exp=1", d_stall);
        end
        step();
        checks++;
        if (dut_e() !== bubble()) begin
            errors++;
            $display("[TB] FAIL load_use_bubble got=%h exp=%h", dut_e(), bubble());
        end
        M_dstM = 4'd0; m_valM = 64'h1234;
        #1;
        checks++;
        if (d_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_use_release got=%b exp=0", d_stall);
        end
        step();
        checks++;
        if (dbus.E_valA !== 64'h1234 || dbus.E_icode !== I_OPQ) begin
            errors++;
            $display("[TB] FAIL load_use_valM got=%h/%h exp=1234/6", dbus.E_valA, dbus.E_icode);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_d(I_OPQ, 4'd1, 4'd3, 64'h0, 64'h0);
        e_dstE = 4'd3; e_valE = 64'd1;
        M_dstE = 4'd3; M_valE = 64'd2;
        W_dstE = 4'd3; W_valE = 64'd3;
        step();
        checks++;
        if (dbus.E_valB !== 64'd1) begin
            errors++;
            $display("[TB] FAIL prio_e got=%h exp=1", dbus.E_valB);
        end
        e_dstE = RN;
        step();
        checks++;
        if (dbus.E_valB !== 64'd2) begin
            errors++;
            $display("[TB] FAIL prio_m got=%h exp=2", dbus.E_valB);
        end
        M_dstE = RN;
        step();
        checks++;
        if (dbus.E_valB !== 64'd3) begin
            errors++;
            $display("[TB] FAIL prio_w got=%h exp=3", dbus.E_valB);
        end
    endtask

    task automatic test_wb_collision();
        do_reset();
        W_dstE = 4'd6; W_valE = 64'd7;
        W_dstM = 4'd6; W_valM = 64'd9;
        step();
        clear_inputs();
        set_d(I_CMOVQ, 4'd6, 4'd0, 64'h0, 64'h0);
        step();
        checks++;
        if (dbus.E_valA !== 64'd9) begin
            errors++;
            $display("[TB] FAIL wb_collision got=%h exp=9", dbus.E_valA);
        end
    endtask

    task automatic test_call_flush();
        do_reset();
        set_d(I_CALL, RN, RN, 64'h100, 64'h40);
        step();
        checks++;
        if (dbus.E_valA !== 64'h40 || dbus.E_srcB !== RSP || dbus.E_dstE !== RSP) begin
            errors++;
            $display("[TB] FAIL call_fields got=%h/%h/%h exp=40/4/4",
                     dbus.E_valA, dbus.E_srcB, dbus.E_dstE);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (dut_e() !== bubble()) begin
            errors++;
            $display("[TB] FAIL flush_bubble got=%h exp=%h", dut_e(), bubble());
        end
    endtask

    task automatic test_hold_reset();
        ereg_t kept;
        do_reset();
        set_d(I_IRMOVQ, RN, 4'd2, 64'h77, 64'h0);
        step();
        kept = '{icode: 4'h3, ifun: 4'h0, valC: 64'h77, valA: 64'h0, valB: 64'h0,
                 srcA: RN, srcB: RN, dstE: 4'd2, dstM: RN};
        hold = 1'b1; flush = 1'b1;
        set_d(I_OPQ, 4'd1, 4'd2, 64'h99, 64'h0);
        step();
        checks++;
        if (dut_e() !== kept) begin
            errors++;
            $display("[TB] FAIL hold_over_flush got=%h exp=%h", dut_e(), kept);
        end
        hold = 1'b0; flush = 1'b0;
        set_d(I_NOP, RN, RN, 64'h0, 64'h0);
        W_dstE = 4'd3; W_valE = 64'hAA;
        step();
        W_dstE = 4'd1; W_valE = 64'hBB;
        set_d(I_OPQ, 4'd1, 4'd2, 64'h5, 64'h0);
        rst = 1'b1;
        step();
        checks++;
        if (dut_e() !== bubble()) begin
            errors++;
            $display("[TB] FAIL mid_reset_bubble got=%h exp=%h", dut_e(), bubble());
        end
        clear_inputs();
        set_d(I_OPQ, 4'd3, 4'd1, 64'h0, 64'h0);
        step();
        checks++;
        if (dbus.E_valA !== 64'h0 || dbus.E_valB !== 64'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_regs got=%h/%h exp=0/0", dbus.E_valA, dbus.E_valB);
        end
    endtask

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return RN;
        if (r == 3) return 4'd14;
        return 4'($urandom_range(0, 5));
    endfunction

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            dbus.D_icode = 4'($urandom_range(0, 15));
            dbus.D_ifun  = 4'($urandom_range(0, 15));
            dbus.D_rA    = pick_reg();
            dbus.D_rB    = pick_reg();
            dbus.D_valC  = {$urandom, $urandom};
            dbus.D_valP  = {$urandom, $urandom};
            e_dstE = pick_reg(); e_valE = {$urandom, $urandom};
            M_dstE = pick_reg(); M_valE = {$urandom, $urandom};
            M_dstM = pick_reg(); m_valM = {$urandom, $urandom};
            W_dstE = pick_reg(); W_valE = {$urandom, $urandom};
            W_dstM = pick_reg(); W_valM = {$urandom, $urandom};
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if (d_stall !== m_load_use()) begin
                errors++;
                $display("[TB] FAIL rand_stall cycle=%0d got=%b exp=%b", n, d_stall, m_load_use());
            end
            step();
            checks++;
            if (dut_e() !== mE) begin
                errors++;
                $display("[TB] FAIL rand_e cycle=%0d got=%h exp=%h", n, dut_e(), mE);
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = 64'h0;
        mE = bubble();
        clear_inputs();
        set_d(I_NOP, RN, RN, 64'h0, 64'h0);
        @(negedge clk);
        test_reset();
        test_fwd_e();
        test_load_use();
        test_priority();
        test_wb_collision();
        test_call_flush();
        test_hold_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
